// File: rtl/fetch_queue_pkg.sv
// Shared front-end types: fetched packet payload and fetch queue depth.
package C;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned SQUASH_ID_W = 4;
   localparam int unsigned FQ_DEPTH    = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
      logic            bp;
   } fetch_data_t;

endpackage

// File: rtl/squash_if.sv
// Pipeline flush request: one-cycle valid pulse with a tag id.
interface squash_if;
   import C::*;

   logic                   valid;
   logic [SQUASH_ID_W-1:0] id;

   modport master (output valid, output id);
   modport slave  (input  valid, input  id);
endinterface

// File: rtl/fetch_queue.sv
// Fetch-to-decode packet FIFO with squash flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: empty-queue 0-cycle pass-through of in_i to out_o.
module fetch_queue
   import C::*;
#(
   parameter int unsigned DEPTH = C::FQ_DEPTH
)
(
   input  logic                       clk,
   input  logic                       rstn,
   input  fetch_data_t                in_i,
   input  logic                       in_i_valid,
   output logic                       in_i_ready,
   output fetch_data_t                out_o,
   output logic                       out_o_valid,
   input  logic                       out_o_ready,
   squash_if.slave                    squash_io,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   fetch_data_t      mem_q [DEPTH];

   logic full_c;
   logic empty_c;
   logic push_c;
   logic pop_c;
   logic bypass_c;

   // Extra pointer MSB separates the full and empty cases when low bits match.
   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

   assign count_o = CNT_W'(wr_ptr_q - rd_ptr_q);

   // Handshake, head selection and push/pop qualification.
   always_comb begin
      in_i_ready  = !full_c;
      out_o_valid = !empty_c && !squash_io.valid;
      out_o       = mem_q[rd_ptr_q[IDX_W-1:0]];
      bypass_c    = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (empty_c && in_i_valid && !squash_io.valid) begin
         out_o       = in_i;
         out_o_valid = 1'b1;
         bypass_c    = out_o_ready;
      end
`endif
      push_c = in_i_valid && in_i_ready && !squash_io.valid && !bypass_c;
      pop_c  = out_o_valid && out_o_ready && !bypass_c;
   end

   // Squash empties the queue and drops this cycle's push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (squash_io.valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage holds no reset; contents are only observed behind valid pointers.
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q[IDX_W-1:0]] <= in_i;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (fill, drain, wrap, squash, async reset, bypass).
module tb_fetch_queue;
   import C::*;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rstn;
   fetch_data_t in_pkt;
   logic        in_valid;
   logic        in_ready;
   fetch_data_t out_pkt;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   squash_if sq ();

   fetch_queue #(.DEPTH(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_i       (in_pkt),
      .in_i_valid (in_valid),
      .in_i_ready (in_ready),
      .out_o      (out_pkt),
      .out_o_valid(out_valid),
      .out_o_ready(out_ready),
      .squash_io  (sq),
      .count_o    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic fetch_data_t mk(input logic [31:0] pc);
      fetch_data_t p;
      p.pc   = pc;
      p.data = ~pc;
      p.bp   = pc[2];
      return p;
   endfunction

   task automatic idle();
      in_valid  = 1'b0;
      in_pkt    = '0;
      out_ready = 1'b0;
      sq.valid  = 1'b0;
   endtask

   initial begin
      rstn     = 1'b1;
      sq.id    = '0;
      idle();
      #3 rstn  = 1'b0;
      #1;
      check_val("reset_count", 128'(count), 128'(0));
      check_val("reset_in_ready", 128'(in_ready), 128'(1));
      check_val("reset_out_valid", 128'(out_valid), 128'(0));
      #20 rstn = 1'b1;
      tick();

      // Fill four entries with decode stalled, then try a fifth.
      for (int i = 0; i < 4; i++) begin
         in_pkt   = mk(32'h8000_0000 + 32'(4 * i));
         in_valid = 1'b1;
         #1;
         check_val("fill_in_ready", 128'(in_ready), 128'(1));
         tick();
      end
      in_pkt = mk(32'h8000_0010);
      #1;
      check_val("full_count", 128'(count), 128'(4));
      check_val("full_in_ready", 128'(in_ready), 128'(0));
      check_val("full_out_valid", 128'(out_valid), 128'(1));
      tick();
      check_val("stall_count", 128'(count), 128'(4));

      // Drain in order.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val("drain_valid", 128'(out_valid), 128'(1));
         check_val("drain_pkt", 128'(out_pkt), 128'(mk(32'h8000_0000 + 32'(4 * i))));
         tick();
      end
      check_val("drain_count", 128'(count), 128'(0));
      check_val("drain_out_valid", 128'(out_valid), 128'(0));

      // Stream ten packets: prime one, then push and pop every cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pkt    = mk(32'h0000_1000);
      tick();
      out_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k < 10) in_pkt = mk(32'h0000_1000 + 32'(4 * k));
         else        in_valid = 1'b0;
         #1;
         check_val("wrap_count", 128'(count), 128'(1));
         check_val("wrap_pkt", 128'(out_pkt), 128'(mk(32'h0000_1000 + 32'(4 * (k - 1)))));
         tick();
      end
      check_val("wrap_end_count", 128'(count), 128'(0));

      // Squash with three held and a concurrent push.
      idle();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_pkt = mk(32'h0000_5000 + 32'(4 * i));
         tick();
      end
      check_val("presquash_count", 128'(count), 128'(3));
      in_pkt    = mk(32'h0000_DEAD);
      out_ready = 1'b1;
      sq.valid  = 1'b1;
      sq.id     = 4'hA;
      #1;
      check_val("squash_out_valid", 128'(out_valid), 128'(0));
      tick();
      idle();
      #1;
      check_val("postsquash_count", 128'(count), 128'(0));
      check_val("postsquash_out_valid", 128'(out_valid), 128'(0));
      in_valid = 1'b1;
      in_pkt   = mk(32'h0000_2000);
      tick();
      in_valid = 1'b0;
      #1;
      check_val("postsquash_push_count", 128'(count), 128'(1));
      check_val("postsquash_head", 128'(out_pkt), 128'(mk(32'h0000_2000)));
      out_ready = 1'b1;
      tick();
      check_val("postsquash_pop_count", 128'(count), 128'(0));

      // Async reset mid-cycle with two held.
      idle();
      in_valid = 1'b1;
      in_pkt   = mk(32'h0000_6000);
      tick();
      in_pkt   = mk(32'h0000_6004);
      tick();
      idle();
      check_val("prereset_count", 128'(count), 128'(2));
      #2 rstn = 1'b0;
      #1;
      check_val("async_count", 128'(count), 128'(0));
      check_val("async_out_valid", 128'(out_valid), 128'(0));
      check_val("async_in_ready", 128'(in_ready), 128'(1));
      #2 rstn = 1'b1;
      tick();
      in_valid = 1'b1;
      in_pkt   = mk(32'h0000_3000);
      tick();
      in_valid = 1'b0;
      #1;
      check_val("postreset_count", 128'(count), 128'(1));
      check_val("postreset_head", 128'(out_pkt), 128'(mk(32'h0000_3000)));
      out_ready = 1'b1;
      tick();
      check_val("postreset_drain_count", 128'(count), 128'(0));

      // Empty queue, push with decode ready.
      idle();
      in_valid  = 1'b1;
      in_pkt    = mk(32'h0000_0100);
      out_ready = 1'b1;
      #1;
      check_val("empty_push_out_valid", 128'(out_valid), 128'(BYP));
      if (BYP) check_val("bypass_pkt", 128'(out_pkt.pc), 128'(32'h0000_0100));
      tick();
      in_valid = 1'b0;
      #1;
      check_val("empty_push_count", 128'(count), BYP ? 128'(0) : 128'(1));
      check_val("empty_push_next_valid", 128'(out_valid), BYP ? 128'(0) : 128'(1));
      tick();
      check_val("final_count", 128'(count), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
